// File: rtl/tod_counter_tz.sv
// rtl/tod_counter_tz.sv - GMT time-of-day counter with prescaler, timezone offset and 12/24h display
module tod_counter_tz #(
  parameter int CLK_DIV    = 50000000,
  parameter int RESET_HOUR = 15,
  parameter int TZ_MIN     = -12,
  parameter int TZ_MAX     = 14
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [17:0] TIME_SETDATA,
  input  logic        TIME_SET_FLAG,
  input  logic [4:0]  TZ_OFFSET,
  input  logic        HOUR12,
  output logic [17:0] DATA,
  output logic        PM,
  output logic        DAY_TICK,
  output logic        SET_ERR
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [4:0]        RST_HOUR   = 5'(RESET_HOUR);
  localparam logic signed [6:0] TZ_LO      = 7'(TZ_MIN);
  localparam logic signed [6:0] TZ_HI      = 7'(TZ_MAX);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          flag_q;
  logic          day_tick_q, day_tick_d;
  logic          set_err_q, set_err_d;
  logic [17:0]   data_q, data_d;
  logic          pm_q, pm_d;

  logic          tick;
  logic          load_req;
  logic          ld_valid;
  logic          do_load;
  logic [4:0]    ld_hour;
  logic [5:0]    ld_min;
  logic [5:0]    ld_sec;

  logic signed [6:0] tz_ext;
  logic signed [6:0] tz_clamped;
  logic signed [6:0] hour_sum;
  logic [4:0]        local_hour;
  logic [4:0]        disp_hour;

  // Tick, rising-edge load request and load-data validation
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    load_req = TIME_SET_FLAG & ~flag_q;
    ld_hour  = TIME_SETDATA[16:12];
    ld_min   = TIME_SETDATA[11:6];
    ld_sec   = TIME_SETDATA[5:0];
    ld_valid = ~TIME_SETDATA[17] && (ld_hour <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
    do_load  = load_req & ld_valid;
  end

  // GMT next state: a valid load overrides the tick, otherwise the tick cascades sec -> min -> hour
  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    day_tick_d = 1'b0;
    set_err_d  = load_req & ~ld_valid;
    if (do_load) begin
      presc_d = '0;
      hour_d  = ld_hour;
      min_d   = ld_min;
      sec_d   = ld_sec;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d     = 5'd0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Local time: clamp offset, wrap hour into 0..23, then optional 12-hour mapping
  always_comb begin
    tz_ext = {{2{TZ_OFFSET[4]}}, TZ_OFFSET};
    if (tz_ext < TZ_LO) begin
      tz_clamped = TZ_LO;
    end else if (tz_ext > TZ_HI) begin
      tz_clamped = TZ_HI;
    end else begin
      tz_clamped = tz_ext;
    end
    hour_sum = $signed({2'b00, hour_q}) + tz_clamped;
    if (hour_sum < 7'sd0) begin
      local_hour = 5'(hour_sum + 7'sd24);
    end else if (hour_sum >= 7'sd24) begin
      local_hour = 5'(hour_sum - 7'sd24);
    end else begin
      local_hour = 5'(hour_sum);
    end
    pm_d      = (local_hour >= 5'd12);
    disp_hour = local_hour;
    if (HOUR12) begin
      if (local_hour == 5'd0) begin
        disp_hour = 5'd12;
      end else if (local_hour > 5'd12) begin
        disp_hour = local_hour - 5'd12;
      end
    end
    data_d = {1'b0, disp_hour, min_q, sec_q};
  end

  // GMT counter, prescaler, flag history and status pulses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      hour_q     <= RST_HOUR;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      flag_q     <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      flag_q     <= TIME_SET_FLAG;
      day_tick_q <= day_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  // Registered display outputs, one cycle behind GMT / offset / mode
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q <= 18'd0;
      pm_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      pm_q   <= pm_d;
    end
  end

  assign DATA     = data_q;
  assign PM       = pm_q;
  assign DAY_TICK = day_tick_q;
  assign SET_ERR  = set_err_q;

endmodule

// File: tb/tb_tod_counter_tz.sv
// tb/tb_tod_counter_tz.sv - scoreboard bench for tod_counter_tz with CLK_DIV=4
module tb_tod_counter_tz;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [17:0] TIME_SETDATA = 18'd0;
  logic        TIME_SET_FLAG = 1'b0;
  logic [4:0]  TZ_OFFSET = 5'd0;
  logic        HOUR12 = 1'b0;
  logic [17:0] DATA;
  logic        PM;
  logic        DAY_TICK;
  logic        SET_ERR;

  tod_counter_tz #(
    .CLK_DIV(4), .RESET_HOUR(15), .TZ_MIN(-12), .TZ_MAX(14)
  ) dut (
    .CLK(CLK), .RESET(RESET), .TIME_SETDATA(TIME_SETDATA), .TIME_SET_FLAG(TIME_SET_FLAG),
    .TZ_OFFSET(TZ_OFFSET), .HOUR12(HOUR12), .DATA(DATA), .PM(PM),
    .DAY_TICK(DAY_TICK), .SET_ERR(SET_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int          cyc;
    logic [17:0] data;
    logic        pm;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {1'b0, 5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic exp_t mk(input int c, input logic [17:0] d, input logic p);
    exp_t e;
    e.cyc = c; e.data = d; e.pm = p;
    return e;
  endfunction

  // Scoreboard: compare DATA/PM against queued expectations at the cycle they fall due
  always @(negedge CLK) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.cyc != cyc)
        $display("FAIL sb_missed due_cyc=%0d now=%0d", e.cyc, cyc);
      else if (DATA !== e.data || PM !== e.pm)
        $display("FAIL sb_data cyc=%0d got DATA=%h PM=%b exp DATA=%h PM=%b", cyc, DATA, PM, e.data, e.pm);
      else
        n_pass++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_load(input logic [17:0] d);
    TIME_SETDATA  = d;
    TIME_SET_FLAG = 1'b1;
    step(1);
    TIME_SET_FLAG = 1'b0;
  endtask

  task automatic test_reset();
    int r;
    step(2);
    n_checks++;
    if (DATA !== 18'd0 || PM !== 1'b0 || DAY_TICK !== 1'b0 || SET_ERR !== 1'b0)
      $display("FAIL reset_state got DATA=%h PM=%b DT=%b SE=%b exp 0", DATA, PM, DAY_TICK, SET_ERR);
    else n_pass++;
    RESET = 1'b0;
    r = cyc;
    exp_q.push_back(mk(r + 1, hms(15, 0, 0), 1'b1));
    exp_q.push_back(mk(r + 4, hms(15, 0, 0), 1'b1));
    exp_q.push_back(mk(r + 5, hms(15, 0, 1), 1'b1));
    exp_q.push_back(mk(r + 240, hms(15, 0, 59), 1'b1));
    exp_q.push_back(mk(r + 241, hms(15, 1, 0), 1'b1));
    step(242);
  endtask

  task automatic test_rollover();
    int l;
    TZ_OFFSET = 5'd0;
    do_load(hms(23, 59, 58));
    l = cyc;
    exp_q.push_back(mk(l + 1, hms(23, 59, 58), 1'b1));
    exp_q.push_back(mk(l + 5, hms(23, 59, 59), 1'b1));
    exp_q.push_back(mk(l + 8, hms(23, 59, 59), 1'b1));
    exp_q.push_back(mk(l + 9, hms(0, 0, 0), 1'b0));
    for (int i = 1; i <= 12; i++) begin
      step(1);
      n_checks++;
      if (DAY_TICK !== (cyc == l + 8))
        $display("FAIL day_tick cyc=%0d got=%b exp=%b", cyc, DAY_TICK, (cyc == l + 8));
      else n_pass++;
    end
  endtask

  task automatic test_load_hold();
    int l;
    TIME_SETDATA  = hms(12, 34, 56);
    TIME_SET_FLAG = 1'b1;
    step(1);
    l = cyc;
    exp_q.push_back(mk(l + 1, hms(12, 34, 56), 1'b1));
    exp_q.push_back(mk(l + 4, hms(12, 34, 56), 1'b1));
    exp_q.push_back(mk(l + 5, hms(12, 34, 57), 1'b1));
    exp_q.push_back(mk(l + 9, hms(12, 34, 58), 1'b1));
    exp_q.push_back(mk(l + 13, hms(12, 34, 59), 1'b1));
    for (int i = 0; i < 9; i++) begin
      step(1);
      n_checks++;
      if (SET_ERR !== 1'b0) $display("FAIL hold_set_err cyc=%0d got=%b exp=0", cyc, SET_ERR);
      else n_pass++;
    end
    TIME_SET_FLAG = 1'b0;
    step(5);
  endtask

  task automatic test_load_invalid();
    int l;
    logic [17:0] bad [3];
    bad[0] = hms(24, 0, 0);
    bad[1] = hms(10, 60, 0);
    bad[2] = hms(1, 2, 3) | 18'h20000;
    do_load(hms(8, 0, 0));
    l = cyc;
    exp_q.push_back(mk(l + 1, hms(8, 0, 0), 1'b0));
    exp_q.push_back(mk(l + 5, hms(8, 0, 1), 1'b0));
    exp_q.push_back(mk(l + 9, hms(8, 0, 2), 1'b0));
    for (int i = 0; i < 3; i++) begin
      step(1);
      do_load(bad[i]);
      n_checks++;
      if (SET_ERR !== 1'b1) $display("FAIL set_err_pulse idx=%0d got=%b exp=1", i, SET_ERR);
      else n_pass++;
    end
    step(1);
    n_checks++;
    if (SET_ERR !== 1'b0) $display("FAIL set_err_clear got=%b exp=0", SET_ERR);
    else n_pass++;
    step(3);
  endtask

  task automatic test_collision();
    int l;
    do_load(hms(23, 59, 59));
    l = cyc;
    exp_q.push_back(mk(l + 1, hms(23, 59, 59), 1'b1));
    exp_q.push_back(mk(l + 5, hms(5, 0, 0), 1'b0));
    exp_q.push_back(mk(l + 8, hms(5, 0, 0), 1'b0));
    exp_q.push_back(mk(l + 9, hms(5, 0, 1), 1'b0));
    step(3);
    do_load(hms(5, 0, 0));
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (DAY_TICK !== 1'b0) $display("FAIL collision_day_tick cyc=%0d got=%b exp=0", cyc, DAY_TICK);
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_timezone();
    int l;
    TZ_OFFSET = 5'd0;
    do_load(hms(2, 10, 0));
    l = cyc;
    TZ_OFFSET = 5'h1B;
    exp_q.push_back(mk(l + 1, hms(21, 10, 0), 1'b1));
    step(1);
    TZ_OFFSET = 5'd14;
    exp_q.push_back(mk(l + 2, hms(16, 10, 0), 1'b1));
    step(1);
    TZ_OFFSET = 5'h10;
    exp_q.push_back(mk(l + 3, hms(14, 10, 0), 1'b1));
    step(1);
    TZ_OFFSET = 5'd0;
    exp_q.push_back(mk(l + 4, hms(2, 10, 0), 1'b0));
    exp_q.push_back(mk(l + 5, hms(2, 10, 1), 1'b0));
    step(2);
    TZ_OFFSET = 5'd3;
    do_load(hms(23, 0, 0));
    l = cyc;
    exp_q.push_back(mk(l + 1, hms(2, 0, 0), 1'b0));
    step(1);
    TZ_OFFSET = 5'd14;
    exp_q.push_back(mk(l + 2, hms(13, 0, 0), 1'b1));
    step(1);
    TZ_OFFSET = 5'd15;
    exp_q.push_back(mk(l + 3, hms(13, 0, 0), 1'b1));
    step(1);
    TZ_OFFSET = 5'd0;
    step(2);
  endtask

  task automatic test_hour12();
    int l;
    HOUR12 = 1'b1;
    TZ_OFFSET = 5'd0;
    do_load(hms(0, 30, 0));
    l = cyc;
    exp_q.push_back(mk(l + 1, hms(12, 30, 0), 1'b0));
    step(1);
    do_load(hms(12, 15, 0));
    exp_q.push_back(mk(l + 3, hms(12, 15, 0), 1'b1));
    step(1);
    do_load(hms(13, 0, 0));
    exp_q.push_back(mk(l + 5, hms(1, 0, 0), 1'b1));
    step(1);
    do_load(hms(11, 59, 59));
    exp_q.push_back(mk(l + 7, hms(11, 59, 59), 1'b0));
    exp_q.push_back(mk(l + 10, hms(11, 59, 59), 1'b0));
    exp_q.push_back(mk(l + 11, hms(12, 0, 0), 1'b1));
    step(6);
    HOUR12 = 1'b0;
    step(1);
  endtask

  task automatic test_async_reset();
    int r;
    TIME_SETDATA  = hms(7, 7, 7);
    TIME_SET_FLAG = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (DATA !== 18'd0 || PM !== 1'b0 || DAY_TICK !== 1'b0 || SET_ERR !== 1'b0)
      $display("FAIL async_reset got DATA=%h PM=%b DT=%b SE=%b exp 0", DATA, PM, DAY_TICK, SET_ERR);
    else n_pass++;
    TIME_SET_FLAG = 1'b0;
    step(2);
    n_checks++;
    if (DATA !== 18'd0) $display("FAIL reset_hold got DATA=%h exp=0", DATA);
    else n_pass++;
    RESET = 1'b0;
    r = cyc;
    exp_q.push_back(mk(r + 1, hms(15, 0, 0), 1'b1));
    exp_q.push_back(mk(r + 4, hms(15, 0, 0), 1'b1));
    exp_q.push_back(mk(r + 5, hms(15, 0, 1), 1'b1));
    step(6);
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_load_hold();
    test_load_invalid();
    test_collision();
    test_timezone();
    test_hour12();
    test_async_reset();
    step(2);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
